// File: rtl/branch_pred_unit.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating counters, carried IF->ID->EX.
// Optional resolved-branch / mispredict statistics counters are built when BRANCH_PRED_STATS_EN is defined.
module branch_pred_unit #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcf,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              br_valid_e,
    input  logic              br_taken_e,
    input  logic [ADDR_W-1:0] br_target_e,
    output logic [ADDR_W-1:0] pce,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int unsigned IDX_W    = $clog2(ENTRIES);
    localparam int unsigned WEAK_T   = 1 << (CNT_W - 1);
    localparam int unsigned CNT_TOP  = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] CntWeakT  = CNT_W'(WEAK_T);
    localparam logic [CNT_W-1:0] CntWeakNt = CNT_W'(WEAK_T - 1);
    localparam logic [CNT_W-1:0] CntMax    = CNT_W'(CNT_TOP);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } pred_t;

    // Prediction table
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_e;
    logic             hit_f;
    logic             hit_e;

    pred_t pred_f;
    pred_t pred_d_q;
    pred_t pred_e_q;

    logic              mispred;
    logic [ADDR_W-1:0] pce_plus4;

    logic              wr_en;
    logic              wr_valid;
    logic [TAG_W-1:0]  wr_tag;
    logic [ADDR_W-1:0] wr_target;
    logic [CNT_W-1:0]  wr_cnt;

    logic unused_pc_bits;

    // IF-stage lookup
    assign idx_f = pcf[IDX_W+1:2];
    assign tag_f = pcf[IDX_W+TAG_W+1:IDX_W+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign pred_taken  = hit_f && cnt_q[idx_f][CNT_W-1];
    assign pred_target = target_q[idx_f];

    assign pred_f = '{pc: pcf, taken: pred_taken, target: pred_target};

    // Pipeline registers; a flush wins over a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_d_q <= '0;
            pred_e_q <= '0;
        end else begin
            if (flush_d) begin
                pred_d_q <= '0;
            end else if (!stall_d) begin
                pred_d_q <= pred_f;
            end
            if (flush_e) begin
                pred_e_q <= '0;
            end else if (!stall_e) begin
                pred_e_q <= pred_d_q;
            end
        end
    end

    assign pce       = pred_e_q.pc;
    assign pce_plus4 = pred_e_q.pc + ADDR_W'(4);

    // EX-stage resolve
    always_comb begin
        mispred = 1'b0;
        if (br_valid_e) begin
            if (pred_e_q.taken != br_taken_e) begin
                mispred = 1'b1;
            end else if (pred_e_q.taken && br_taken_e && (pred_e_q.target != br_target_e)) begin
                mispred = 1'b1;
            end
        end else if (pred_e_q.taken) begin
            mispred = 1'b1;
        end
    end

    // rst gates redirect so nothing leaks out while the pipeline is being cleared
    assign redirect    = rst && !stall_e && mispred;
    assign redirect_pc = !redirect ? '0 :
                         (br_valid_e && br_taken_e) ? br_target_e : pce_plus4;

    // Table update for the instruction resolving in EX
    assign idx_e = pred_e_q.pc[IDX_W+1:2];
    assign tag_e = pred_e_q.pc[IDX_W+TAG_W+1:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[idx_e];
        wr_tag    = tag_q[idx_e];
        wr_target = target_q[idx_e];
        wr_cnt    = cnt_q[idx_e];
        if (!stall_e) begin
            if (br_valid_e) begin
                if (hit_e) begin
                    wr_en = 1'b1;
                    if (br_taken_e) begin
                        wr_target = br_target_e;
                        if (wr_cnt != CntMax) begin
                            wr_cnt = wr_cnt + 1'b1;
                        end
                    end else if (wr_cnt != '0) begin
                        wr_cnt = wr_cnt - 1'b1;
                    end
                end else if (br_taken_e) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = tag_e;
                    wr_target = br_target_e;
                    wr_cnt    = CntWeakT;
                end
            end else if (pred_e_q.taken) begin
                // Aliased prediction on a non-branch: drop the entry
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CntWeakNt;
            end
        end else if (wr_en) begin
            valid_q[idx_e]  <= wr_valid;
            tag_q[idx_e]    <= wr_tag;
            target_q[idx_e] <= wr_target;
            cnt_q[idx_e]    <= wr_cnt;
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (!stall_e) begin
            if (br_valid_e) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (redirect) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

    // Byte-offset and upper PC bits never take part in index/tag
    assign unused_pc_bits = ^{pcf, pred_e_q.pc};

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios plus randomized traffic
// against a table/pipeline reference model.
module tb_branch_pred_unit;

    localparam int Half   = 2;
    localparam int CntMax = 3;
`ifdef BRANCH_PRED_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall_d, flush_d, stall_e, flush_e;
    logic        br_valid_e, br_taken_e;
    logic [31:0] br_target_e;
    logic [31:0] pce;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt, mispred_cnt;

    int nc = 0;
    int nf = 0;

    // Reference model state
    bit          mv   [64];
    int          mtag [64];
    logic [31:0] mtgt [64];
    int          mcnt [64];
    logic [31:0] d_pc, d_tgt, e_pc, e_tgt;
    bit          d_pt, e_pt;
    int unsigned mb, mm;
    bit          exp_pt, exp_redir;
    logic [31:0] exp_ptgt, exp_rpc;

    always #5 clk = ~clk;

    branch_pred_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pcf         (pcf),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .br_valid_e  (br_valid_e),
        .br_taken_e  (br_taken_e),
        .br_target_e (br_target_e),
        .pce         (pce),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic logic [31:0] exp_bc();
        return StatsOn ? 32'(mb) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_mc();
        return StatsOn ? 32'(mm) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = '0; mcnt[i] = Half - 1;
        end
        d_pc = '0; d_tgt = '0; d_pt = 0;
        e_pc = '0; e_tgt = '0; e_pt = 0;
        mb = 0; mm = 0;
    endtask

    // Apply inputs on the falling edge and compute what the outputs must be this cycle
    task automatic drive(input bit rst_v, input logic [31:0] pc, input bit sd, fd, se, fe, bv, bt,
                         input logic [31:0] tgt);
        int i;
        @(negedge clk);
        rst = rst_v; pcf = pc; stall_d = sd; flush_d = fd; stall_e = se; flush_e = fe;
        br_valid_e = bv; br_taken_e = bt; br_target_e = tgt;
        #1;
        if (!rst_v) model_reset();
        i = idx_of(pc);
        exp_pt   = mv[i] && (mtag[i] == tag_of(pc)) && (mcnt[i] >= Half);
        exp_ptgt = mtgt[i];
        exp_redir = 0;
        if (rst_v && !se) begin
            if (bv && (e_pt != bt)) exp_redir = 1;
            if (bv && e_pt && bt && (e_tgt != tgt)) exp_redir = 1;
            if (!bv && e_pt) exp_redir = 1;
        end
        exp_rpc = !exp_redir ? 32'd0 : (bv && bt) ? tgt : e_pc + 32'd4;
    endtask

    // Clock edge: evolve the model with the inputs held this cycle
    task automatic advance();
        int  i;
        bit  hit;
        @(posedge clk);
        if (!rst) return;
        if (!stall_e) begin
            i   = idx_of(e_pc);
            hit = mv[i] && (mtag[i] == tag_of(e_pc));
            if (br_valid_e) begin
                mb++;
                if (hit) begin
                    if (br_taken_e) begin
                        if (mcnt[i] < CntMax) mcnt[i]++;
                        mtgt[i] = br_target_e;
                    end else if (mcnt[i] > 0) begin
                        mcnt[i]--;
                    end
                end else if (br_taken_e) begin
                    mv[i] = 1; mtag[i] = tag_of(e_pc); mtgt[i] = br_target_e; mcnt[i] = Half;
                end
            end else if (e_pt) begin
                mv[i] = 0;
            end
            if (exp_redir) mm++;
        end
        if (flush_e) begin
            e_pc = '0; e_pt = 0; e_tgt = '0;
        end else if (!stall_e) begin
            e_pc = d_pc; e_pt = d_pt; e_tgt = d_tgt;
        end
        if (flush_d) begin
            d_pc = '0; d_pt = 0; d_tgt = '0;
        end else if (!stall_d) begin
            d_pc = pcf; d_pt = exp_pt; d_tgt = exp_ptgt;
        end
    endtask

    // Fetch pc, two more fetches behind it, resolve pc in EX on the third cycle
    task automatic issue_branch(input logic [31:0] pc, input bit bv, bt, input logic [31:0] tgt,
                                output bit o_pt, output logic [31:0] o_ptgt,
                                output bit o_redir, output logic [31:0] o_rpc);
        drive(1, pc, 0, 0, 0, 0, 0, 0, '0);
        o_pt = pred_taken; o_ptgt = pred_target;
        advance();
        drive(1, pc + 32'd4, 0, 0, 0, 0, 0, 0, '0);
        advance();
        drive(1, pc + 32'd8, 0, 0, 0, 0, bv, bt, tgt);
        o_redir = redirect; o_rpc = redirect_pc;
        advance();
    endtask

    task automatic test_reset();
        drive(0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h80);
        nc++; if (redirect !== 1'b0) begin nf++; $display("FAIL rst_redirect: got %b want 0", redirect); end
        nc++; if (pred_taken !== 1'b0) begin nf++; $display("FAIL rst_pt: got %b want 0", pred_taken); end
        nc++; if (pred_target !== 32'h0) begin nf++; $display("FAIL rst_ptgt: got %h want 0", pred_target); end
        nc++; if (pce !== 32'h0) begin nf++; $display("FAIL rst_pce: got %h want 0", pce); end
        nc++; if (redirect_pc !== 32'h0) begin nf++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
        nc++; if (branch_cnt !== 32'h0) begin nf++; $display("FAIL rst_bcnt: got %0d want 0", branch_cnt); end
        nc++; if (mispred_cnt !== 32'h0) begin nf++; $display("FAIL rst_mcnt: got %0d want 0", mispred_cnt); end
        advance();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, '0);
        nc++; if (pred_taken !== 1'b0) begin nf++; $display("FAIL post_rst_pt: got %b want 0", pred_taken); end
        nc++; if (redirect !== 1'b0) begin nf++; $display("FAIL post_rst_redirect: got %b want 0", redirect); end
        advance();
    endtask

    task automatic test_train();
        bit          pt, rd;
        logic [31:0] ptgt, rpc;
        issue_branch(32'h100, 1, 1, 32'h80, pt, ptgt, rd, rpc);
        nc++; if (pt !== 1'b0) begin nf++; $display("FAIL train_first_pt: got %b want 0", pt); end
        nc++; if (rd !== 1'b1) begin nf++; $display("FAIL train_miss_redirect: got %b want 1", rd); end
        nc++; if (rpc !== 32'h80) begin nf++; $display("FAIL train_miss_rpc: got %h want 80", rpc); end
        for (int k = 0; k < 3; k++) begin
            issue_branch(32'h100, 1, 1, 32'h80, pt, ptgt, rd, rpc);
            nc++; if (pt !== 1'b1) begin nf++; $display("FAIL train_pt[%0d]: got %b want 1", k, pt); end
            nc++; if (ptgt !== 32'h80) begin nf++; $display("FAIL train_ptgt[%0d]: got %h want 80", k, ptgt); end
            nc++; if (rd !== 1'b0) begin nf++; $display("FAIL train_redirect[%0d]: got %b want 0", k, rd); end
        end
        // Saturated at 3: one not-taken drops to 2 and still predicts taken
        issue_branch(32'h100, 1, 0, 32'h0, pt, ptgt, rd, rpc);
        nc++; if (rd !== 1'b1) begin nf++; $display("FAIL nt_redirect: got %b want 1", rd); end
        nc++; if (rpc !== 32'h104) begin nf++; $display("FAIL nt_rpc: got %h want 104", rpc); end
    endtask

    task automatic test_alias();
        bit          pt, rd;
        logic [31:0] ptgt, rpc;
        issue_branch(32'h100, 0, 0, 32'h0, pt, ptgt, rd, rpc);
        nc++; if (pt !== 1'b1) begin nf++; $display("FAIL after_nt_pt: got %b want 1", pt); end
        nc++; if (rd !== 1'b1) begin nf++; $display("FAIL alias_redirect: got %b want 1", rd); end
        nc++; if (rpc !== 32'h104) begin nf++; $display("FAIL alias_rpc: got %h want 104", rpc); end
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, '0);
        nc++; if (pred_taken !== 1'b0) begin nf++; $display("FAIL alias_inval_pt: got %b want 0", pred_taken); end
        advance();
    endtask

    task automatic test_stall_flush();
        drive(1, 32'h240, 0, 0, 0, 0, 0, 0, '0); advance();
        drive(1, 32'h244, 0, 0, 0, 0, 0, 0, '0); advance();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h240, 1, 0, 1, 0, 1, 1, 32'h300);
            nc++; if (redirect !== 1'b0) begin nf++; $display("FAIL stall_redirect[%0d]: got %b want 0", k, redirect); end
            nc++; if (pred_taken !== 1'b0) begin nf++; $display("FAIL stall_nowrite[%0d]: got %b want 0", k, pred_taken); end
            nc++; if (pce !== 32'h240) begin nf++; $display("FAIL stall_pce[%0d]: got %h want 240", k, pce); end
            nc++; if (branch_cnt !== exp_bc()) begin nf++; $display("FAIL stall_bcnt[%0d]: got %0d want %0d", k, branch_cnt, exp_bc()); end
            advance();
        end
        drive(1, 32'h240, 0, 1, 0, 1, 1, 1, 32'h300);
        nc++; if (redirect !== 1'b1) begin nf++; $display("FAIL release_redirect: got %b want 1", redirect); end
        nc++; if (redirect_pc !== 32'h300) begin nf++; $display("FAIL release_rpc: got %h want 300", redirect_pc); end
        advance();
        nc++; if (branch_cnt !== exp_bc()) begin nf++; $display("FAIL release_bcnt: got %0d want %0d", branch_cnt, exp_bc()); end
        drive(1, 32'h240, 0, 0, 0, 0, 0, 0, '0);
        nc++; if (pred_taken !== 1'b1) begin nf++; $display("FAIL stall_written_pt: got %b want 1", pred_taken); end
        nc++; if (pred_target !== 32'h300) begin nf++; $display("FAIL stall_written_tgt: got %h want 300", pred_target); end
        advance();
        drive(1, 32'h250, 0, 0, 0, 1, 0, 0, '0);
        advance();
        drive(1, 32'h254, 0, 0, 0, 0, 0, 0, '0);
        nc++; if (pce !== 32'h0) begin nf++; $display("FAIL flush_pce: got %h want 0", pce); end
        nc++; if (redirect !== 1'b0) begin nf++; $display("FAIL flush_redirect: got %b want 0", redirect); end
        advance();
    endtask

    task automatic test_stats();
        bit          pt, rd;
        logic [31:0] ptgt, rpc;
        logic [31:0] want_b, want_m;
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, '0); advance();
        for (int k = 0; k < 10; k++) begin
            if (k < 3) issue_branch(32'h400 + 32'(k * 'h100), 1, 1, 32'h900, pt, ptgt, rd, rpc);
            else       issue_branch(32'h440 + 32'(k * 'h10), 1, 0, 32'h0, pt, ptgt, rd, rpc);
        end
        drive(1, 32'h800, 0, 0, 0, 0, 0, 0, '0);
        want_b = StatsOn ? 32'd10 : 32'd0;
        want_m = StatsOn ? 32'd3 : 32'd0;
        nc++; if (branch_cnt !== want_b) begin nf++; $display("FAIL stats_branch: got %0d want %0d", branch_cnt, want_b); end
        nc++; if (mispred_cnt !== want_m) begin nf++; $display("FAIL stats_mispred: got %0d want %0d", mispred_cnt, want_m); end
        advance();
    endtask

    task automatic test_random();
        bit          r, sd, fd, se, fe, bv, bt;
        logic [31:0] pc, tgt;
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, '0); advance();
        for (int c = 0; c < 600; c++) begin
            r   = !(c >= 300 && c < 302);
            pc  = ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h2000) + 32'(4 * $urandom_range(0, 7));
            tgt = 32'h3000 + 32'(4 * $urandom_range(0, 3));
            se  = ($urandom_range(0, 7) == 0);
            sd  = se | ($urandom_range(0, 15) == 0);
            fd  = ($urandom_range(0, 15) == 0);
            fe  = ($urandom_range(0, 15) == 0);
            bv  = ($urandom_range(0, 1) != 0);
            bt  = ($urandom_range(0, 2) != 0);
            drive(r, pc, sd, fd, se, fe, bv, bt, tgt);
            nc++; if (pred_taken !== exp_pt) begin nf++; $display("FAIL rnd_pt c=%0d: got %b want %b", c, pred_taken, exp_pt); end
            nc++; if (pred_target !== exp_ptgt) begin nf++; $display("FAIL rnd_ptgt c=%0d: got %h want %h", c, pred_target, exp_ptgt); end
            nc++; if (redirect !== exp_redir) begin nf++; $display("FAIL rnd_redirect c=%0d: got %b want %b", c, redirect, exp_redir); end
            nc++; if (pce !== e_pc) begin nf++; $display("FAIL rnd_pce c=%0d: got %h want %h", c, pce, e_pc); end
            if (exp_redir) begin
                nc++; if (redirect_pc !== exp_rpc) begin nf++; $display("FAIL rnd_rpc c=%0d: got %h want %h", c, redirect_pc, exp_rpc); end
            end
            nc++; if (branch_cnt !== exp_bc()) begin nf++; $display("FAIL rnd_bcnt c=%0d: got %0d want %0d", c, branch_cnt, exp_bc()); end
            nc++; if (mispred_cnt !== exp_mc()) begin nf++; $display("FAIL rnd_mcnt c=%0d: got %0d want %0d", c, mispred_cnt, exp_mc()); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0; pcf = '0; stall_d = 0; flush_d = 0; stall_e = 0; flush_e = 0;
        br_valid_e = 0; br_taken_e = 0; br_target_e = '0;
        model_reset();
        test_reset();
        test_train();
        test_alias();
        test_stall_flush();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline; successor to the fixed-size BTB/BHT predictors.
- Combines a direct-mapped BTB with per-entry N-bit saturating counters.
- Looks up the IF-stage PC in the same cycle and carries the prediction down through ID and EX, honouring stalls and flushes.
- Resolves the prediction in EX against the actual branch outcome, updates the table, and issues a redirect on a mispredict.

Parameters:
- ENTRIES, 64, table depth; power of 2, minimum 4.
- CNT_W, 2, saturating counter width; 1 to 4.
- TAG_W, 8, tag bits stored per entry.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- pcf  in  ADDR_W  IF-stage PC.
- pred_taken  out  1  IF predicts taken.
- pred_target  out  ADDR_W  predicted next PC; valid only when pred_taken=1.
- stall_d  in  1  hold the ID prediction register.
- flush_d  in  1  clear the ID prediction register.
- stall_e  in  1  hold the EX prediction register.
- flush_e  in  1  clear the EX prediction register.
- br_valid_e  in  1  the EX instruction is a conditional branch.
- br_taken_e  in  1  actual branch outcome in EX.
- br_target_e  in  ADDR_W  actual branch target computed in EX.
- pce  out  ADDR_W  PC carried to EX by this block.
- redirect  out  1  mispredict detected in EX; hazard unit flushes D and E.
- redirect_pc  out  ADDR_W  correct next PC, valid when redirect=1.
- branch_cnt  out  32  resolved-branch counter (see Optional Feature).
- mispred_cnt  out  32  mispredict counter (see Optional Feature).

Behaviour:
- Index and tag:
  - IDX_W = log2(ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry contents: valid, tag, target[ADDR_W], cnt[CNT_W].
- Lookup (combinational from pcf):
  - hit = valid && tag match.
  - pred_taken = hit && cnt[CNT_W-1].
  - pred_target = entry target.
  - Lookup reads the pre-edge table contents; a same-cycle update to the same index is not bypassed.
- Pipeline registers, IF->ID and ID->EX, each holding {pc, pred_taken, pred_target}:
  - Clear has priority over stall.
  - The IF->ID register obeys flush_d/stall_d.
  - The ID->EX register obeys flush_e/stall_e.
  - A cleared register holds pc=0, pred_taken=0.
- Resolve (combinational in EX, gated by !stall_e):
  - redirect=1 if br_valid_e && (pred_taken_e != br_taken_e).
  - redirect=1 if br_valid_e && pred_taken_e && br_taken_e && (pred_target_e != br_target_e).
  - redirect=1 if !br_valid_e && pred_taken_e (alias on a non-branch).
  - redirect_pc = (br_valid_e && br_taken_e) ? br_target_e : pce+4.
- Update (at the clock edge when !stall_e, one write per cycle):
  - Branch, hit: cnt saturating +1 if taken, -1 if not taken; no wrap at 0 or 2^CNT_W-1. Target rewritten on taken.
  - Branch, miss, taken: allocate with valid=1, new tag, target=br_target_e, cnt=2^(CNT_W-1) (weakly taken). Any existing entry at that index is overwritten.
  - Branch, miss, not taken: no write.
  - Non-branch with pred_taken_e=1: invalidate the entry at idx(pce).
- Reset (async assert, sync-safe deassert):
  - All entries: valid=0, cnt=2^(CNT_W-1)-1.
  - Pipeline registers cleared.
  - All outputs 0, counters 0.
- Reset mid-operation: the table is lost and in-flight predictions are dropped; no redirect is issued during reset.

Optional Feature:
- Macro: BRANCH_PRED_STATS_EN.
- Defined:
  - branch_cnt increments once per cycle with br_valid_e && !stall_e.
  - mispred_cnt increments once per cycle with redirect && !stall_e.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are built.

Test Plan:
- Reset, then pcf=0x100 -> pred_taken=0; all outputs 0.
- Branch at pce=0x100 resolved taken to 0x80 (miss) -> redirect=1, redirect_pc=0x80. Next pcf=0x100 -> pred_taken=1, pred_target=0x80 (cnt=2).
- Same branch taken 3 more times -> cnt saturates at 3. Then one not-taken -> redirect=1, redirect_pc=0x104, cnt=2, and the next lookup still predicts taken.
- Alias: entry at 0x100 predicted taken, EX instruction with br_valid_e=0 -> redirect=1, redirect_pc=0x104. Next lookup of 0x100 -> pred_taken=0.
- stall_e=1 for 3 cycles during resolve -> no table write and no counter increment until the stall releases; flush_e clears pred_taken_e and no redirect follows.
- With BRANCH_PRED_STATS_EN, 10 branches with 3 mispredicts -> branch_cnt=10, mispred_cnt=3; without the macro both read 0.
